lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL provide parameter LOCK_COUNT, default 4: consecutive matches needed to declare lock.
REQ-002 SHALL provide parameter LOSS_COUNT, default 3: consecutive locked mismatches that drop lock.
REQ-003 SHALL provide parameter CNT_W, default 16: width of err_count.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_data is a sample this cycle.
REQ-007 SHALL have port in_data  input  9  received pseudo-random word.
REQ-008 SHALL have port clr_cnt  input  1  synchronous clear of err_count.
REQ-009 SHALL have port locked  output  1  checker is synchronised to the sequence.
REQ-010 SHALL have port err_pulse  output  1  one-cycle flag per locked mismatch.
REQ-011 SHALL have port err_count  output  CNT_W  saturating locked-mismatch count.
REQ-012 SHALL have port stuck  output  1  all-zero lock-up word detected.

Function
REQ-013 SHALL predict pred = {prev[7:0], prev[8]^prev[4]} (x^9+x^5+1), prev = last accepted word.
REQ-014 SHALL accept a sample only when in_valid=1; with in_valid=0 no state, counter or output changes, and err_pulse is 0.
REQ-015 SHALL skip comparison on the first accepted sample after reset (have_prev=0); it only loads prev.
REQ-016 SHALL load prev with every accepted in_data, matched or not (self-resynchronising).
REQ-017 SHALL implement FSM SEARCH/LOCKED; all outputs registered, updated on the edge that accepts the sample.
REQ-018 In SEARCH: match increments hit_run; mismatch clears hit_run; mismatches are not errors.
REQ-019 SHALL move SEARCH->LOCKED and set locked=1 on the accepted match making hit_run reach LOCK_COUNT.
REQ-020 In LOCKED: mismatch sets err_pulse=1 for one cycle, increments err_count and miss_run; match clears miss_run.
REQ-021 SHALL move LOCKED->SEARCH, set locked=0 and clear hit_run and miss_run on the mismatch making miss_run reach LOSS_COUNT; that mismatch still counts as an error.
REQ-022 SHALL saturate err_count at 2^CNT_W-1; no wrap.
REQ-023 clr_cnt=1 SHALL zero err_count; clr_cnt with a simultaneous error SHALL yield err_count=1.
REQ-024 SHALL not affect FSM, locked or run counters via clr_cnt.

Reset
REQ-025 While reset=1 (asynchronously): state=SEARCH, have_prev=0, prev=0, hit_run=0, miss_run=0, locked=0, err_pulse=0, err_count=0, stuck=0.
REQ-026 After reset release the first accepted sample SHALL be treated per REQ-015.

Configuration
REQ-027 With macro LFSR_CHECKER_STUCK_DET_EN defined: stuck SHALL be set on acceptance of in_data=9'h000 and clear on the next accepted non-zero word; a zero word also forces a mismatch.
REQ-028 Without LFSR_CHECKER_STUCK_DET_EN: stuck SHALL be constant 0, detection logic absent, zero words compared per REQ-013.

Verification
REQ-029 Reset, then valid 001,002,004,008,010 -> locked=1 after 5th sample's edge, err_count=0, err_pulse never 1.
REQ-030 Locked on sequence, replace one word with 0FF -> two err_pulses (corrupt word and the next), err_count=2, locked stays 1.
REQ-031 Locked, three garbage words then correct sequence -> locked=0 after 3rd mismatch, err_count=3, relock after 4 further matches.
REQ-032 Scenario REQ-029 with in_valid low every other cycle -> identical accepted-sample results, no change on idle cycles.
REQ-033 clr_cnt=1 on the cycle of a locked mismatch -> err_count=1; with CNT_W=2 and five locked errors -> err_count stays 3.
REQ-034 Macro defined, accept 000 -> stuck=1 next cycle, cleared after a non-zero word; macro undefined -> stuck=0 throughout.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: x^9+x^5+1 pseudo-random sequence checker with SEARCH/LOCKED lock tracking and a saturating error count.
// Optional all-zero lock-up detection on `stuck` is built when LFSR_CHECKER_STUCK_DET_EN is defined.
module lfsr_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [8:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             stuck
);

  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(LOSS_COUNT + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_nxt;
  logic             have_prev, have_prev_nxt;
  logic [8:0]       prev, prev_nxt;
  logic [HW-1:0]    hit_run, hit_nxt;
  logic [MW-1:0]    miss_run, miss_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [8:0]       pred;
  logic             zero_word;
  logic             match;

  assign pred = {prev[7:0], prev[8] ^ prev[4]};

`ifdef LFSR_CHECKER_STUCK_DET_EN
  // An all-zero word is the LFSR lock-up state, so it never counts as a match.
  assign zero_word = (in_data == 9'h000);
`else
  assign zero_word = 1'b0;
`endif

  assign match = (in_data == pred) && !zero_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      have_prev <= 1'b0;
      prev      <= '0;
      hit_run   <= '0;
      miss_run  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      have_prev <= have_prev_nxt;
      prev      <= prev_nxt;
      hit_run   <= hit_nxt;
      miss_run  <= miss_nxt;
      err_pulse <= err_nxt;
      err_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    have_prev_nxt = have_prev;
    prev_nxt      = prev;
    hit_nxt       = hit_run;
    miss_nxt      = miss_run;
    err_nxt       = 1'b0;
    cnt_nxt       = err_count;

    if (in_valid) begin
      have_prev_nxt = 1'b1;
      prev_nxt      = in_data;
      if (have_prev) begin
        case (state)
          SEARCH: begin
            if (!match) begin
              hit_nxt = '0;
            end else if (hit_run == HW'(LOCK_COUNT - 1)) begin
              state_nxt = LOCKED;
              hit_nxt   = '0;
            end else begin
              hit_nxt = hit_run + HW'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              miss_nxt = '0;
            end else begin
              err_nxt = 1'b1;
              if (miss_run == MW'(LOSS_COUNT - 1)) begin
                state_nxt = SEARCH;
                hit_nxt   = '0;
                miss_nxt  = '0;
              end else begin
                miss_nxt = miss_run + MW'(1);
              end
            end
          end
          default: state_nxt = SEARCH;
        endcase
      end
    end

    // A clear coinciding with an error leaves that error counted.
    if (clr_cnt) begin
      cnt_nxt = CNT_W'(err_nxt);
    end else if (err_nxt && (err_count != {CNT_W{1'b1}})) begin
      cnt_nxt = err_count + CNT_W'(1);
    end
  end

  assign locked = (state == LOCKED);

`ifdef LFSR_CHECKER_STUCK_DET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stuck <= 1'b0;
    end else if (in_valid) begin
      stuck <= zero_word;
    end
  end
`else
  assign stuck = 1'b0;
`endif

endmodule
